// File: rtl/vga_pkg.sv
// Shared definitions for the VGA mode sequencer: mode codes, counter width
// and the sequencer FSM state type.
package vga_pkg;

  localparam int unsigned MODE_MENU     = 0;
  localparam int unsigned MODE_REACTION = 1;
  localparam int unsigned MODE_CHIMP    = 2;

  // Blank-frame counter width; BLANK_FRAMES is limited to 255 so it never wraps.
  localparam int unsigned COUNT_W = 8;

  typedef enum logic [1:0] {
    ST_STABLE   = 2'd0,
    ST_PENDING  = 2'd1,
    ST_BLANKING = 2'd2
  } state_e;

endpackage

// File: rtl/mode_onehot_dec.sv
// Combinational mode-code to one-hot decoder; out-of-range codes give all-zero.
module mode_onehot_dec #(
  parameter int unsigned NUM_MODES = 3,
  parameter int unsigned MODE_W    = 2
) (
  input  logic [MODE_W-1:0]    code,
  output logic [NUM_MODES-1:0] onehot
);

  // One bit per legal code; at most one can match.
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NUM_MODES; i++) begin
      if (code == MODE_W'(i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/vga_mode_sequencer.sv
// VGA screen-enable sequencer: defers mode changes to a frame boundary and
// inserts BLANK_FRAMES full black frames between the old and new screen.
module vga_mode_sequencer
  import vga_pkg::*;
#(
  parameter int unsigned NUM_MODES    = 3,
  parameter int unsigned MODE_W       = 2,
  parameter int unsigned BLANK_FRAMES = 2,
  parameter int unsigned DEFAULT_MODE = MODE_MENU
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MODE_W-1:0]    iGameMode,
  input  logic                 iFrameStart,
  output logic [NUM_MODES-1:0] oEnable,
  output logic                 oBlank,
  output logic [MODE_W-1:0]    oActiveMode,
  output logic                 oSwitchDone
);

  localparam logic [MODE_W-1:0]    DEF_CODE   = MODE_W'(DEFAULT_MODE);
  localparam logic [NUM_MODES-1:0] DEF_ONEHOT = NUM_MODES'(1) << DEFAULT_MODE;
  localparam logic [COUNT_W-1:0]   LAST_CNT   = COUNT_W'(BLANK_FRAMES - 1);

  state_e               state_q,  state_d;
  logic [MODE_W-1:0]    target_q, target_d;
  logic [COUNT_W-1:0]   count_q,  count_d;
  logic [MODE_W-1:0]    active_q, active_d;
  logic [NUM_MODES-1:0] enable_q, enable_d;
  logic                 blank_q,  blank_d;
  logic                 done_q,   done_d;

  logic [NUM_MODES-1:0] target_onehot;
  logic                 mode_differs;
  logic                 last_frame;

  mode_onehot_dec #(
    .NUM_MODES (NUM_MODES),
    .MODE_W    (MODE_W)
  ) u_dec (
    .code   (target_q),
    .onehot (target_onehot)
  );

  assign mode_differs = (iGameMode != active_q);
  assign last_frame   = iFrameStart && (count_q == LAST_CNT);

  // State and output registers with synchronous reset to the default mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_STABLE;
      target_q <= DEF_CODE;
      count_q  <= '0;
      active_q <= DEF_CODE;
      enable_q <= DEF_ONEHOT;
      blank_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      count_q  <= count_d;
      active_q <= active_d;
      enable_q <= enable_d;
      blank_q  <= blank_d;
      done_q   <= done_d;
    end
  end

  // Next-state: a cancel in PENDING beats a coincident frame pulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STABLE:   if (mode_differs) state_d = ST_PENDING;
      ST_PENDING: begin
        if (!mode_differs)    state_d = ST_STABLE;
        else if (iFrameStart) state_d = ST_BLANKING;
      end
      ST_BLANKING: if (last_frame) state_d = ST_STABLE;
      default:     state_d = ST_STABLE;
    endcase
  end

  // Next values of target, blank counter and the registered outputs.
  always_comb begin
    target_d = target_q;
    count_d  = count_q;
    active_d = active_q;
    enable_d = enable_q;
    blank_d  = blank_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_STABLE: if (mode_differs) target_d = iGameMode;
      ST_PENDING: begin
        target_d = iGameMode;
        if (mode_differs && iFrameStart) begin
          enable_d = '0;
          blank_d  = 1'b1;
          count_d  = '0;
        end
      end
      ST_BLANKING: begin
        target_d = iGameMode;
        if (last_frame) begin
          active_d = target_q;
          enable_d = target_onehot;
          blank_d  = (target_onehot == '0);
          done_d   = 1'b1;
          count_d  = '0;
        end else if (iFrameStart) begin
          count_d = count_q + COUNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign oEnable     = enable_q;
  assign oBlank      = blank_q;
  assign oActiveMode = active_q;
  assign oSwitchDone = done_q;

endmodule
